// File: rtl/reg_si_master_if.sv
// Host byte link in, Simple Interface register write bus out.
// The master modport is the reg_si_master side; slave is the host/consumer side.
interface reg_si_master_if #(
    parameter int REG_DATA_WIDTH = 16,
    parameter int REG_ADDR_WIDTH = 8
);
    logic [7:0]                rx_data;
    logic                      rx_rdy;
    logic [REG_ADDR_WIDTH-1:0] reg_si_addr;
    logic [REG_DATA_WIDTH-1:0] reg_si_data;
    logic                      reg_si_rdy;
    logic                      frame_err;
    logic                      busy;

    modport master (
        input  rx_data,
        input  rx_rdy,
        output reg_si_addr,
        output reg_si_data,
        output reg_si_rdy,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_data,
        output rx_rdy,
        input  reg_si_addr,
        input  reg_si_data,
        input  reg_si_rdy,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/reg_si_master.sv
// Assembles address/data byte frames into single-cycle register writes.
// A frame is one address byte followed by REG_DATA_WIDTH/8 data bytes, MSB first.
module reg_si_master #(
    parameter int REG_DATA_WIDTH = 16,
    parameter int REG_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst,
    reg_si_master_if.master bus
);
    localparam int N_DB = REG_DATA_WIDTH / 8;
    localparam int CW   = $clog2(N_DB + 1);
    localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N_DB - 1);
    localparam logic [TW-1:0] TO_LAST  = (TIMEOUT_CYCLES > 0) ? TW'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic {IDLE, DATA} state_t;

    state_t                    state, state_d;
    logic [CW-1:0]             byte_cnt, byte_cnt_d;
    logic [TW-1:0]             to_cnt, to_cnt_d;
    logic [REG_ADDR_WIDTH-1:0] addr_hold, addr_hold_d;
    logic [REG_DATA_WIDTH-1:0] data_sr, data_sr_d, next_sr;
    logic [REG_ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [REG_DATA_WIDTH-1:0] data_q, data_d;
    logic                      rdy_q, rdy_d;
    logic                      err_q, err_d;
    logic                      busy_q, busy_d;

    // Older bytes fall off the top, so after N_DB shifts the register holds exactly one frame.
    assign next_sr = REG_DATA_WIDTH'({data_sr, bus.rx_data});

    always_comb begin
        state_d     = state;
        byte_cnt_d  = byte_cnt;
        to_cnt_d    = to_cnt;
        addr_hold_d = addr_hold;
        data_sr_d   = data_sr;
        addr_d      = addr_q;
        data_d      = data_q;
        rdy_d       = 1'b0;
        err_d       = 1'b0;

        case (state)
            IDLE: begin
                if (bus.rx_rdy) begin
                    addr_hold_d = bus.rx_data[REG_ADDR_WIDTH-1:0];
                    byte_cnt_d  = '0;
                    to_cnt_d    = '0;
                    data_sr_d   = '0;
                    state_d     = DATA;
                end
            end
            DATA: begin
                if (bus.rx_rdy) begin
                    // An arriving byte always beats a timeout expiring in the same cycle.
                    data_sr_d  = next_sr;
                    byte_cnt_d = byte_cnt + 1'b1;
                    to_cnt_d   = '0;
                    if (byte_cnt == LAST_CNT) begin
                        addr_d  = addr_hold;
                        data_d  = next_sr;
                        rdy_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (TIMEOUT_CYCLES != 0) begin
                    if (to_cnt == TO_LAST) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        to_cnt_d = to_cnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == DATA);
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            state     <= IDLE;
            byte_cnt  <= '0;
            to_cnt    <= '0;
            addr_hold <= '0;
            data_sr   <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            rdy_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state     <= state_d;
            byte_cnt  <= byte_cnt_d;
            to_cnt    <= to_cnt_d;
            addr_hold <= addr_hold_d;
            data_sr   <= data_sr_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            rdy_q     <= rdy_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.reg_si_addr = addr_q;
    assign bus.reg_si_data = data_q;
    assign bus.reg_si_rdy  = rdy_q;
    assign bus.frame_err   = err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_reg_si_master.sv
// Scoreboard bench for reg_si_master: a frame-level byte model predicts writes,
// timeouts and per-cycle output state; a monitor compares them against the bus.
module tb_reg_si_master;
    localparam int TO = 10;

    logic clk_i = 1'b0;
    logic rst   = 1'b1;

    reg_si_master_if #(.REG_DATA_WIDTH(16), .REG_ADDR_WIDTH(8)) bus ();

    reg_si_master #(
        .REG_DATA_WIDTH(16),
        .REG_ADDR_WIDTH(8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int         cycle;
        bit         is_err;
        logic [7:0] addr;
        logic [15:0] data;
    } ev_t;

    typedef struct {
        int         cycle;
        bit         busy;
        bit         rdy;
        bit         err;
        logic [7:0] addr;
        logic [15:0] data;
    } st_t;

    ev_t evq[$];
    st_t stq[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: bytes of the frame in progress, idle gap, and last written values
    byte unsigned frame[$];
    int           idle   = 0;
    logic [7:0]   m_addr = '0;
    logic [15:0]  m_data = '0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [7:0] d);
        bit w  = 1'b0;
        bit er = 1'b0;
        int k;
        @(negedge clk_i);
        rst         = r;
        bus.rx_rdy  = v;
        bus.rx_data = d;
        k = cyc;
        if (r) begin
            frame.delete();
            idle   = 0;
            m_addr = '0;
            m_data = '0;
        end else if (v) begin
            frame.push_back(d);
            idle = 0;
            if (frame.size() == 3) begin
                m_addr = frame[0];
                m_data = {frame[1], frame[2]};
                w = 1'b1;
                evq.push_back('{k + 1, 1'b0, m_addr, m_data});
                frame.delete();
            end
        end else if (frame.size() > 0) begin
            idle++;
            if (idle == TO) begin
                er = 1'b1;
                evq.push_back('{k + 1, 1'b1, m_addr, m_data});
                frame.delete();
                idle = 0;
            end
        end
        stq.push_back('{k + 1, frame.size() > 0, w, er, m_addr, m_data});
    endtask

    task automatic idleCycles(input int n);
        repeat (n) applyStimulus(1'b0, 1'b0, 8'h00);
    endtask

    // Monitor: pop a scoreboard event on every strobe, and check held state each cycle.
    always @(negedge clk_i) begin : monitor
        ev_t e;
        st_t s;
        if (bus.reg_si_rdy === 1'b1 || bus.frame_err === 1'b1) begin
            if (evq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_strobe at cycle %0d: rdy=%b err=%b, expected none",
                         cyc, bus.reg_si_rdy, bus.frame_err);
            end else begin
                e = evq.pop_front();
                checkOutput("event_cycle", cyc, e.cycle);
                checkOutput("event_kind_err", {31'b0, bus.frame_err}, {31'b0, e.is_err});
                if (!e.is_err) begin
                    checkOutput("write_addr", {24'b0, bus.reg_si_addr}, {24'b0, e.addr});
                    checkOutput("write_data", {16'b0, bus.reg_si_data}, {16'b0, e.data});
                end
            end
        end
        if (stq.size() > 0 && stq[0].cycle == cyc) begin
            s = stq.pop_front();
            checkOutput("busy", {31'b0, bus.busy}, {31'b0, s.busy});
            checkOutput("reg_si_rdy", {31'b0, bus.reg_si_rdy}, {31'b0, s.rdy});
            checkOutput("frame_err", {31'b0, bus.frame_err}, {31'b0, s.err});
            checkOutput("held_addr", {24'b0, bus.reg_si_addr}, {24'b0, s.addr});
            checkOutput("held_data", {16'b0, bus.reg_si_data}, {16'b0, s.data});
        end
    end

    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [7:0] contig [6];
        contig = '{8'h00, 8'h12, 8'h34, 8'h01, 8'hAB, 8'hCD};
        bus.rx_rdy  = 1'b0;
        bus.rx_data = 8'h00;

        repeat (3) applyStimulus(1'b1, 1'b0, 8'h00);
        idleCycles(2);

        // Single default frame
        applyStimulus(1'b0, 1'b1, 8'h02);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h05);
        idleCycles(3);

        // Two fully contiguous frames
        for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, contig[i]);
        idleCycles(3);

        // Timeout, then a clean frame
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h12);
        idleCycles(10);
        applyStimulus(1'b0, 1'b1, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h07);
        idleCycles(3);

        // Byte arriving in the expiry cycle wins
        applyStimulus(1'b0, 1'b1, 8'h33);
        idleCycles(9);
        applyStimulus(1'b0, 1'b1, 8'h44);
        idleCycles(9);
        applyStimulus(1'b0, 1'b1, 8'h55);
        idleCycles(3);

        // Reset mid-frame with rx_rdy ignored during reset
        applyStimulus(1'b0, 1'b1, 8'h02);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b1, 1'b1, 8'hEE);
        applyStimulus(1'b0, 1'b1, 8'h05);
        applyStimulus(1'b0, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h09);
        idleCycles(3);

        // Strobe gaps below the timeout
        applyStimulus(1'b0, 1'b1, 8'h7F);
        idleCycles($urandom_range(0, 5));
        applyStimulus(1'b0, 1'b1, 8'hFF);
        idleCycles($urandom_range(0, 5));
        applyStimulus(1'b0, 1'b1, 8'hFF);
        idleCycles(3);

        // Randomized traffic with occasional long gaps and resets
        for (int i = 0; i < 3000; i++) begin
            int p;
            p = $urandom_range(0, 99);
            if (p < 2)
                applyStimulus(1'b1, 1'($urandom_range(0, 1)), 8'($urandom));
            else if (p < 55)
                applyStimulus(1'b0, 1'b1, 8'($urandom));
            else if (p < 59)
                idleCycles($urandom_range(8, 12));
            else
                applyStimulus(1'b0, 1'b0, 8'($urandom));
        end

        idleCycles(TO + 2);
        @(negedge clk_i);
        #1;
        checkOutput("pending_events", evq.size(), 0);
        checkOutput("pending_states", stq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/reg_si_master.md
# reg_si_master

Byte-stream to register-bus master. It assembles address/data frames arriving from the host byte link, for example the USB FIFO receive path, and issues single-cycle writes on the Simple Interface register bus. That bus is shared by `adc_block` and the other configurable blocks. It is the writer end of that bus: every `reg_si_rdy` pulse it produces is one register write.

## Interface
- `REG_DATA_WIDTH`, default 16: register data width; must be a multiple of 8. `N_DB = REG_DATA_WIDTH/8` data bytes per frame.
- `REG_ADDR_WIDTH`, default 8: register address width; must be 8 or less.
- `TIMEOUT_CYCLES`, default 1000000: maximum idle gap between bytes inside a frame; 0 disables the timeout.

Ports:
- `clk_i`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte; valid only when `rx_rdy` is 1.
- `rx_rdy`  in  1  one-cycle strobe per byte. There is no backpressure; every strobe is consumed.
- `reg_si_addr`  out  `REG_ADDR_WIDTH`  write address; held between writes.
- `reg_si_data`  out  `REG_DATA_WIDTH`  write data; held between writes.
- `reg_si_rdy`  out  1  one-cycle write strobe.
- `frame_err`  out  1  one-cycle pulse when a partial frame is discarded on timeout.
- `busy`  out  1  high while a frame is partially received (state DATA).

## Operation
- Frame format: byte 0 is the address; bytes 1..`N_DB` are data, MSB first. Default frame is addr, data[15:8], data[7:0].
- Address truncation: `reg_si_addr` = byte0[`REG_ADDR_WIDTH`-1:0]. Upper bits are ignored.
- FSM states:
  - IDLE: `rx_rdy` latches the address into a holding register, clears the byte count and the timeout counter, and goes to DATA.
  - DATA: each `rx_rdy` shifts the byte into the data shift register (`data_sr <= {data_sr, rx_data}`), increments the byte count and clears the timeout counter.
  - DATA, last byte: on the `rx_rdy` that brings the count to `N_DB`, the FSM loads `reg_si_addr` and `reg_si_data` from the holding/shift registers plus the incoming byte, sets `reg_si_rdy` to 1 for the next cycle, and goes to IDLE.
- Timeout: in DATA without `rx_rdy`, the counter increments. When it reaches `TIMEOUT_CYCLES`-1, the FSM goes to IDLE, pulses `frame_err`, and leaves outputs unchanged. The counter saturates and does not wrap. With `TIMEOUT_CYCLES`=0 the counter is held at 0 and never fires.
- Timeout versus `rx_rdy` in the same cycle: the byte wins. It is accepted and the counter clears.
- Partial frames never produce a write. `reg_si_addr` and `reg_si_data` change only together with a `reg_si_rdy` pulse.
- Reset (any cycle, including mid-frame):
  - state goes to IDLE; byte count, timeout counter and holding registers clear to 0;
  - `reg_si_addr`=0, `reg_si_data`=0, `reg_si_rdy`=0, `frame_err`=0, `busy`=0;
  - a partial frame is dropped silently with no `frame_err`;
  - while `rst` is 1, `rx_rdy` is ignored.

## Timing
- All outputs are registered.
- Latency: `reg_si_rdy` is high in cycle N+1, where N is the cycle the final data byte's `rx_rdy` is sampled. It is high for exactly one cycle.
- Back-to-back bytes: `rx_rdy` may be high every cycle. A new frame's address byte is accepted in cycle N+1, the same cycle `reg_si_rdy` is high, so frames can be fully contiguous with no gap.
- Maximum write rate is one write per `N_DB`+1 cycles.
- `busy` rises in the cycle after the address byte is sampled. It falls in the cycle after the final byte, or after the timeout cycle.
- `frame_err` is high in the cycle after the timeout cycle and lasts one cycle.
- Consumers must sample `reg_si_addr` and `reg_si_data` in the cycle `reg_si_rdy` is high; both remain stable after that until the next write.

## Test plan
- Single frame, defaults: bytes 0x02, 0x00, 0x05 on consecutive cycles -> one `reg_si_rdy` pulse with addr=0x02 and data=0x0005; `busy` high for 2 cycles.
- Contiguous frames: 0x00,0x12,0x34,0x01,0xAB,0xCD with `rx_rdy` held high for 6 cycles -> writes (0x00,0x1234) then (0x01,0xABCD), exactly 3 cycles apart; no `frame_err`.
- Timeout with `TIMEOUT_CYCLES`=10: send 0x00, 0x12, then idle 10 cycles -> `frame_err` pulses once, no write. Then 0x01,0x00,0x07 -> write (0x01,0x0007).
- Timeout boundary with `TIMEOUT_CYCLES`=10: after the address byte, assert the next byte at gap 9 (same cycle as the expiry condition) -> byte accepted, frame completes normally, no `frame_err`.
- Reset mid-frame: 0x02, 0x00, then `rst` for 1 cycle, then 0x05,0x00,0x09 -> single write (0x05,0x0009); outputs read 0 immediately after reset; no `frame_err`.
- Strobe gaps: bytes 0x7F,0xFF,0xFF separated by random gaps of 0-5 cycles with `TIMEOUT_CYCLES`=10 -> write (0x7F,0xFFFF); addr/data unchanged between strobes.
